// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - PS/2 and button driven player centre with per-frame clamped motion
module player_motion_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int HALF   = 25,
  parameter int STEP   = 4,
  parameter int INIT_X = 320,
  parameter int INIT_Y = 240
) (
  input  logic        i_clk_25mHz,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_BTNU,
  input  logic        i_BTNL,
  input  logic        i_BTNR,
  input  logic        i_BTND,
  input  logic        i_screenEnd,
  input  logic        i_move_en,
  input  logic        i_recenter,
  output logic [31:0] o_accel_x,
  output logic [31:0] o_accel_y,
  output logic [3:0]  o_dir_held,
  output logic        o_frame_tick
);

  localparam logic signed [11:0] LP_STEP   = 12'(STEP);
  localparam logic signed [11:0] LP_LO     = 12'(HALF);
  localparam logic signed [11:0] LP_X_HI   = 12'(WIDTH - 1 - HALF);
  localparam logic signed [11:0] LP_Y_HI   = 12'(HEIGHT - 1 - HALF);
  localparam logic [11:0]        LP_INIT_X = 12'(INIT_X);
  localparam logic [11:0]        LP_INIT_Y = 12'(INIT_Y);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } dec_state_t;

  dec_state_t  r_state;
  logic [3:0]  r_kw;
  logic [3:0]  r_ka;
  logic [3:0]  r_btn_s1;
  logic [3:0]  r_btn_s2;
  logic [3:0]  r_dir_held;
  logic        r_se_q;
  logic        r_frame_tick;
  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [3:0]  w_map_n;
  logic [3:0]  w_map_e;
  logic        w_is_e0;
  logic        w_is_f0;

  // One axis step: move toward whichever single side is held, then clamp to the visible range
  function automatic logic [11:0] f_step(input logic [11:0] pos, input logic inc,
                                         input logic dec, input logic signed [11:0] hi);
    logic signed [11:0] v;
    v = $signed(pos);
    if (inc && !dec) begin
      v = v + LP_STEP;
    end else if (dec && !inc) begin
      v = v - LP_STEP;
    end
    if (v < LP_LO) begin
      v = LP_LO;
    end else if (v > hi) begin
      v = hi;
    end
    return $unsigned(v);
  endfunction

  // Scan-code to {up, down, left, right} lookup for plain and E0-prefixed codes
  always_comb begin
    w_map_n = 4'b0000;
    w_map_e = 4'b0000;
    w_is_e0 = (i_rx_data == 8'hE0);
    w_is_f0 = (i_rx_data == 8'hF0);
    case (i_rx_data)
      8'h1D:   w_map_n = 4'b1000;
      8'h1B:   w_map_n = 4'b0100;
      8'h1C:   w_map_n = 4'b0010;
      8'h23:   w_map_n = 4'b0001;
      default: w_map_n = 4'b0000;
    endcase
    case (i_rx_data)
      8'h75:   w_map_e = 4'b1000;
      8'h72:   w_map_e = 4'b0100;
      8'h6B:   w_map_e = 4'b0010;
      8'h74:   w_map_e = 4'b0001;
      default: w_map_e = 4'b0000;
    endcase
  end

  // Prefix-tracking decoder; the terminating byte of a sequence updates the key flags
  always_ff @(posedge i_clk_25mHz or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_kw    <= 4'b0000;
      r_ka    <= 4'b0000;
    end else if (i_rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_e0) begin
            r_state <= S_EXT;
          end else if (w_is_f0) begin
            r_state <= S_BRK;
          end else begin
            r_kw <= r_kw | w_map_n;
          end
        end
        S_EXT: begin
          if (w_is_f0) begin
            r_state <= S_EXT_BRK;
          end else if (!w_is_e0) begin
            r_ka    <= r_ka | w_map_e;
            r_state <= S_IDLE;
          end
        end
        S_BRK: begin
          if (w_is_e0) begin
            r_state <= S_EXT_BRK;
          end else if (!w_is_f0) begin
            r_kw    <= r_kw & ~w_map_n;
            r_state <= S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (!w_is_e0 && !w_is_f0) begin
            r_ka    <= r_ka & ~w_map_e;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-flop synchronisers for the raw buttons, packed as {up, down, left, right}
  always_ff @(posedge i_clk_25mHz or negedge i_reset) begin
    if (!i_reset) begin
      r_btn_s1 <= 4'b0000;
      r_btn_s2 <= 4'b0000;
    end else begin
      r_btn_s1 <= {i_BTNU, i_BTND, i_BTNL, i_BTNR};
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Merged held directions and single-cycle frame tick on a screenEnd rise
  always_ff @(posedge i_clk_25mHz or negedge i_reset) begin
    if (!i_reset) begin
      r_dir_held   <= 4'b0000;
      r_se_q       <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_dir_held   <= r_kw | r_ka | r_btn_s2;
      r_se_q       <= i_screenEnd;
      r_frame_tick <= i_screenEnd & ~r_se_q;
    end
  end

  // Per-frame position update; recenter outranks move_en
  always_ff @(posedge i_clk_25mHz or negedge i_reset) begin
    if (!i_reset) begin
      r_x <= LP_INIT_X;
      r_y <= LP_INIT_Y;
    end else if (r_frame_tick) begin
      if (i_recenter) begin
        r_x <= LP_INIT_X;
        r_y <= LP_INIT_Y;
      end else if (i_move_en) begin
        r_x <= f_step(r_x, r_dir_held[0], r_dir_held[1], LP_X_HI);
        r_y <= f_step(r_y, r_dir_held[2], r_dir_held[3], LP_Y_HI);
      end
    end
  end

  assign o_accel_x    = {20'd0, r_x};
  assign o_accel_y    = {20'd0, r_y};
  assign o_dir_held   = r_dir_held;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// tb/tb_player_motion_ctrl.sv - randomized and directed checks of player_motion_ctrl against a behavioural model
module tb_player_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        btnu, btnl, btnr, btnd;
  logic        se;
  logic        move_en;
  logic        recenter;
  logic [31:0] accel_x, accel_y;
  logic [3:0]  dir_held;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  int max_x    = 0;

  // behavioural model state
  int       m_x, m_y;
  bit [3:0] m_kw, m_ka, m_s1, m_s2, m_dir;
  bit       m_tick, m_seq, m_ext, m_brk;

  logic [7:0] pool [10] = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74};

  player_motion_ctrl dut (
    .i_clk_25mHz (clk),
    .i_reset     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_valid  (rx_valid),
    .i_BTNU      (btnu),
    .i_BTNL      (btnl),
    .i_BTNR      (btnr),
    .i_BTND      (btnd),
    .i_screenEnd (se),
    .i_move_en   (move_en),
    .i_recenter  (recenter),
    .o_accel_x   (accel_x),
    .o_accel_y   (accel_y),
    .o_dir_held  (dir_held),
    .o_frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // direction index in {up,down,left,right} order (3..0), -1 if unmapped
  function automatic int key_idx(input logic [7:0] b, input bit ext);
    if (!ext) begin
      if (b == 8'h1D) return 3;
      if (b == 8'h1B) return 2;
      if (b == 8'h1C) return 1;
      if (b == 8'h23) return 0;
    end else begin
      if (b == 8'h75) return 3;
      if (b == 8'h72) return 2;
      if (b == 8'h6B) return 1;
      if (b == 8'h74) return 0;
    end
    return -1;
  endfunction

  function automatic bit [3:0] upd(input bit [3:0] f, input int idx, input bit val);
    bit [3:0] r;
    r = f;
    if (idx >= 0) r[idx] = val;
    return r;
  endfunction

  function automatic int delta(input bit pos, input bit neg);
    if (pos && !neg) return 4;
    if (neg && !pos) return -4;
    return 0;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // reference: key sets from a prefix-flag byte parser, position as clamped integers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_x <= 320; m_y <= 240;
      m_kw <= 0; m_ka <= 0; m_s1 <= 0; m_s2 <= 0; m_dir <= 0;
      m_tick <= 0; m_seq <= 0; m_ext <= 0; m_brk <= 0;
    end else begin
      if (m_tick) begin
        if (recenter) begin
          m_x <= 320; m_y <= 240;
        end else if (move_en) begin
          m_x <= clampi(m_x + delta(m_dir[0], m_dir[1]), 25, 614);
          m_y <= clampi(m_y + delta(m_dir[2], m_dir[3]), 25, 454);
        end
      end
      m_tick <= se && !m_seq;
      m_seq  <= se;
      m_dir  <= m_kw | m_ka | m_s2;
      m_s2   <= m_s1;
      m_s1   <= {btnu, btnd, btnl, btnr};
      if (rx_valid) begin
        if (rx_data == 8'hE0) m_ext <= 1'b1;
        else if (rx_data == 8'hF0) m_brk <= 1'b1;
        else begin
          if (m_ext) m_ka <= upd(m_ka, key_idx(rx_data, 1'b1), !m_brk);
          else       m_kw <= upd(m_kw, key_idx(rx_data, 1'b0), !m_brk);
          m_ext <= 1'b0;
          m_brk <= 1'b0;
        end
      end
    end
  end

  // cycle-by-cycle comparison shortly after each active edge
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("accel_x", accel_x, 32'(m_x));
      chk("accel_y", accel_y, 32'(m_y));
      chk("dir_held", 32'(dir_held), 32'(m_dir));
      chk("frame_tick", 32'(frame_tick), 32'(m_tick));
      if (frame_tick) tick_cnt++;
      if (int'(accel_x) > max_x) max_x = int'(accel_x);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk); se = 1'b1;
      @(negedge clk); se = 1'b0;
      idle(2);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    btnu = 0; btnl = 0; btnr = 0; btnd = 0;
    se = 0; move_en = 1'b1; recenter = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("reset_x", accel_x, 32'd320);
    chk("reset_y", accel_y, 32'd240);
    chk("reset_dir", 32'(dir_held), 32'd0);
    chk("reset_tick", 32'(frame_tick), 32'd0);

    // 1: idle frames
    tick_cnt = 0;
    tick(3);
    chk("t1_x", accel_x, 32'd320);
    chk("t1_y", accel_y, 32'd240);
    chk("t1_ticks", 32'(tick_cnt), 32'd3);

    // 2: W make then break
    send_byte(8'h1D); idle(3);
    tick(4);
    chk("t2_y_up", accel_y, 32'd224);
    send_byte(8'hF0); send_byte(8'h1D); idle(3);
    tick(1);
    chk("t2_y_hold", accel_y, 32'd224);
    chk("t2_dir", 32'(dir_held), 32'd0);

    // 3: right arrow plus BTNR saturates at the right edge
    send_byte(8'hE0); send_byte(8'h74);
    btnr = 1'b1; idle(4);
    max_x = 0;
    tick(80);
    chk("t3_x_sat", accel_x, 32'd614);
    chk("t3_x_max", 32'(max_x), 32'd614);
    btnr = 1'b0;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74); idle(4);
    chk("t3_dir_right", 32'(dir_held[0]), 32'd0);

    recenter = 1'b1; tick(1); recenter = 1'b0;
    chk("recenter_x", accel_x, 32'd320);

    // 4: opposing buttons cancel, up moves
    btnl = 1'b1; btnr = 1'b1; btnu = 1'b1; idle(4);
    tick(10);
    chk("t4_x", accel_x, 32'd320);
    chk("t4_y", accel_y, 32'd200);

    // 5: move_en low, recenter, long screenEnd
    btnl = 0; btnr = 0; btnu = 0; btnd = 1'b1; move_en = 1'b0; idle(4);
    tick(5);
    chk("t5_hold_y", accel_y, 32'd200);
    recenter = 1'b1; tick(1); recenter = 1'b0;
    chk("t5_rc_x", accel_x, 32'd320);
    chk("t5_rc_y", accel_y, 32'd240);
    btnd = 1'b0; move_en = 1'b1;
    tick_cnt = 0;
    @(negedge clk); se = 1'b1;
    idle(100);
    se = 1'b0; idle(3);
    chk("t5_one_tick", 32'(tick_cnt), 32'd1);

    // 6: reset discards a pending E0
    send_byte(8'hE0);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    send_byte(8'h75); idle(4);
    chk("t6_dir", 32'(dir_held), 32'd0);
    chk("t6_x", accel_x, 32'd320);
    chk("t6_y", accel_y, 32'd240);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst_n    = ($urandom_range(0, 799) != 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) {btnu, btnd, btnl, btnr} = 4'($urandom);
      if ($urandom_range(0, 11) == 0) se = ~se;
      move_en  = ($urandom_range(0, 7) != 0);
      recenter = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1; rx_valid = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
